execute_cycle: RTL and testbench

Execute stage of the 5-stage RV32IM pipeline: takes the decoded instruction from the ID/EX boundary, resolves forwarded operands, computes ALU / multiply / branch-target results, and registers everything into the EX/MEM boundary that feeds the memory stage. Integer division and remainder run on an iterative radix-2 divider that stalls the front of the pipeline while it runs. Branch and jump decisions are resolved here and returned to fetch.

---
 rtl/riscv_pkg.sv | 58 +++++
 rtl/riscv_divider.sv | 135 +++++++++++++
 rtl/execute_cycle.sv | 184 ++++++++++++++++++
 tb/tb_execute_cycle.sv | 456 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// riscv_pkg: shared encodings for the RV32IM execute stage.
// ALU ops, branch types, forward selects, divider states.
package riscv_pkg;

  typedef enum logic [4:0] {
    ALU_ADD    = 5'd0,
    ALU_SUB    = 5'd1,
    ALU_AND    = 5'd2,
    ALU_OR     = 5'd3,
    ALU_XOR    = 5'd4,
    ALU_SLL    = 5'd5,
    ALU_SRL    = 5'd6,
    ALU_SRA    = 5'd7,
    ALU_SLT    = 5'd8,
    ALU_SLTU   = 5'd9,
    ALU_MUL    = 5'd10,
    ALU_MULH   = 5'd11,
    ALU_MULHSU = 5'd12,
    ALU_MULHU  = 5'd13,
    ALU_DIV    = 5'd14,
    ALU_DIVU   = 5'd15,
    ALU_REM    = 5'd16,
    ALU_REMU   = 5'd17
  } alu_op_e;

  typedef enum logic [2:0] {
    BR_BEQ  = 3'b000,
    BR_BNE  = 3'b001,
    BR_BLT  = 3'b100,
    BR_BGE  = 3'b101,
    BR_BLTU = 3'b110,
    BR_BGEU = 3'b111
  } br_type_e;

  localparam logic [1:0] FWD_RD = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  typedef enum logic [1:0] {
    DIV_IDLE,
    DIV_RUN,
    DIV_DONE
  } div_state_e;

  typedef struct packed {
    logic        regw;
    logic        memw;
    logic [2:0]  rsrc;
    logic [2:0]  dex;
    logic [4:0]  rd;
    logic [31:0] pcp4;
    logic [31:0] wd;
    logic [31:0] alu;
    logic [31:0] imm;
    logic [31:0] pct;
  } ex_mem_t;

endpackage

// File: rtl/riscv_divider.sv
// riscv_divider: iterative radix-2 restoring divider.
// Signed/unsigned div and rem; special cases finish at once.
module riscv_divider
  import riscv_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_flush,
  input  logic        i_start,
  input  alu_op_e     i_op,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic        o_busy,
  output logic        o_done,
  output logic [31:0] o_result
);

  div_state_e  r_state;
  div_state_e  w_next;
  logic [4:0]  r_cnt;
  logic [31:0] r_quo;
  logic [31:0] r_rem;
  logic [31:0] r_dvs;
  logic        r_negq;
  logic        r_negr;
  logic        r_isrem;

  logic        w_signed;
  logic        w_isrem;
  logic        w_ovf;
  logic        w_special;
  logic        w_go;
  logic [31:0] w_abs_a;
  logic [31:0] w_abs_b;
  logic [31:0] w_spec;
  logic [31:0] w_q;
  logic [31:0] w_r;
  logic [32:0] w_shift;
  logic [32:0] w_diff;

  assign w_signed  = (i_op == ALU_DIV) || (i_op == ALU_REM);
  assign w_isrem   = (i_op == ALU_REM) || (i_op == ALU_REMU);
  assign w_ovf     = w_signed && (i_a == 32'h8000_0000)
                     && (i_b == 32'hFFFF_FFFF);
  assign w_special = (i_b == 32'd0) || w_ovf;
  assign w_go      = i_start && !w_special;
  assign w_abs_a   = (w_signed && i_a[31]) ? -i_a : i_a;
  assign w_abs_b   = (w_signed && i_b[31]) ? -i_b : i_b;

  // Partial remainder trial subtract; bit 32 set means borrow.
  assign w_shift = {r_rem, r_quo[31]};
  assign w_diff  = w_shift - {1'b0, r_dvs};

  assign w_q = r_negq ? -r_quo : r_quo;
  assign w_r = r_negr ? -r_rem : r_rem;

  // Divide-by-zero and signed overflow results.
  always_comb begin
    w_spec = 32'd0;
    if (i_b == 32'd0)
      w_spec = w_isrem ? i_a : 32'hFFFF_FFFF;
    else
      w_spec = w_isrem ? 32'd0 : 32'h8000_0000;
  end

  // Next-state and handshake outputs.
  always_comb begin
    w_next = r_state;
    o_busy = 1'b0;
    o_done = 1'b0;
    unique case (r_state)
      DIV_IDLE: begin
        o_busy = w_go;
        o_done = i_start && w_special;
        if (w_go)
          w_next = DIV_RUN;
      end
      DIV_RUN: begin
        o_busy = 1'b1;
        if (i_flush)
          w_next = DIV_IDLE;
        else if (r_cnt == 5'd31)
          w_next = DIV_DONE;
      end
      DIV_DONE: begin
        o_done = 1'b1;
        w_next = DIV_IDLE;
      end
      default: w_next = DIV_IDLE;
    endcase
  end

  assign o_result = (r_state == DIV_DONE)
                    ? (r_isrem ? w_r : w_q)
                    : w_spec;

  // State register.
  always_ff @(posedge clk) begin
    if (rst)
      r_state <= DIV_IDLE;
    else
      r_state <= w_next;
  end

  // Operand latch and one restoring step per RUN cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt   <= 5'd0;
      r_quo   <= 32'd0;
      r_rem   <= 32'd0;
      r_dvs   <= 32'd0;
      r_negq  <= 1'b0;
      r_negr  <= 1'b0;
      r_isrem <= 1'b0;
    end else if (r_state == DIV_IDLE && w_go) begin
      r_cnt   <= 5'd0;
      r_quo   <= w_abs_a;
      r_rem   <= 32'd0;
      r_dvs   <= w_abs_b;
      r_negq  <= w_signed && (i_a[31] ^ i_b[31]);
      r_negr  <= w_signed && i_a[31];
      r_isrem <= w_isrem;
    end else if (r_state == DIV_RUN) begin
      r_cnt <= r_cnt + 5'd1;
      if (!w_diff[32]) begin
        r_rem <= w_diff[31:0];
        r_quo <= {r_quo[30:0], 1'b1};
      end else begin
        r_rem <= w_shift[31:0];
        r_quo <= {r_quo[30:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/execute_cycle.sv
// execute_cycle: EX stage of the RV32IM pipeline.
// Forwarding, ALU/mul, branch resolve, divider, EX/MEM reg.
module execute_cycle
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            CLK,
  input  logic            Rst,
  input  logic            RegWriteE,
  input  logic            MemWriteE,
  input  logic            BranchE,
  input  logic            JumpE,
  input  logic            ALUSrcE,
  input  logic [2:0]      ResultSrcE,
  input  logic [2:0]      DexControlE,
  input  logic [2:0]      BranchTypeE,
  input  logic [4:0]      ALUControlE,
  input  logic [XLEN-1:0] RD1_E,
  input  logic [XLEN-1:0] RD2_E,
  input  logic [XLEN-1:0] Imm_Ext_E,
  input  logic [XLEN-1:0] PC_E,
  input  logic [XLEN-1:0] PCPlus4E,
  input  logic [4:0]      RD_E,
  input  logic [1:0]      ForwardAE,
  input  logic [1:0]      ForwardBE,
  input  logic [XLEN-1:0] ResultW,
  input  logic            FlushE,
  output logic            StallE,
  output logic            PCSrcE,
  output logic [XLEN-1:0] PCTargetE,
  output logic            RegWriteM,
  output logic            MemWriteM,
  output logic [2:0]      ResultSrcM,
  output logic [2:0]      DexControlM,
  output logic [4:0]      RD_M,
  output logic [XLEN-1:0] PCPlus4M,
  output logic [XLEN-1:0] WriteDataM,
  output logic [XLEN-1:0] ALU_ResultM,
  output logic [XLEN-1:0] Imm_Ext_M,
  output logic [XLEN-1:0] PCTargetM
);

  ex_mem_t     r_exm;
  ex_mem_t     w_exm;
  alu_op_e     w_op;
  logic [31:0] w_srca;
  logic [31:0] w_wd;
  logic [31:0] w_srcb;
  logic [31:0] w_alu;
  logic [31:0] w_div_res;
  logic        w_div_done;
  logic        w_is_div;
  logic        w_sa;
  logic        w_sb;
  logic [63:0] w_pa;
  logic [63:0] w_pb;
  logic [63:0] w_prod;
  logic        w_cond;
  logic        w_jalr;

  assign w_op = alu_op_e'(ALUControlE);

  // Operand forwarding.
  always_comb begin
    w_srca = RD1_E;
    w_wd   = RD2_E;
    if (ForwardAE == FWD_W)
      w_srca = ResultW;
    else if (ForwardAE == FWD_M)
      w_srca = r_exm.alu;
    if (ForwardBE == FWD_W)
      w_wd = ResultW;
    else if (ForwardBE == FWD_M)
      w_wd = r_exm.alu;
  end

  assign w_srcb = ALUSrcE ? Imm_Ext_E : w_wd;

  // One 64-bit product; operand extension picks the MULH flavour.
  assign w_sa   = (w_op == ALU_MULH) || (w_op == ALU_MULHSU);
  assign w_sb   = (w_op == ALU_MULH);
  assign w_pa   = {{32{w_sa & w_srca[31]}}, w_srca};
  assign w_pb   = {{32{w_sb & w_srcb[31]}}, w_srcb};
  assign w_prod = w_pa * w_pb;

  assign w_is_div = (w_op == ALU_DIV) || (w_op == ALU_DIVU)
                    || (w_op == ALU_REM) || (w_op == ALU_REMU);

  riscv_divider u_div (
    .clk      (CLK),
    .rst      (Rst),
    .i_flush  (FlushE),
    .i_start  (w_is_div && !FlushE),
    .i_op     (w_op),
    .i_a      (w_srca),
    .i_b      (w_srcb),
    .o_busy   (StallE),
    .o_done   (w_div_done),
    .o_result (w_div_res)
  );

  // ALU result select.
  always_comb begin
    w_alu = 32'd0;
    case (w_op)
      ALU_ADD:    w_alu = w_srca + w_srcb;
      ALU_SUB:    w_alu = w_srca - w_srcb;
      ALU_AND:    w_alu = w_srca & w_srcb;
      ALU_OR:     w_alu = w_srca | w_srcb;
      ALU_XOR:    w_alu = w_srca ^ w_srcb;
      ALU_SLL:    w_alu = w_srca << w_srcb[4:0];
      ALU_SRL:    w_alu = w_srca >> w_srcb[4:0];
      ALU_SRA:    w_alu = $unsigned($signed(w_srca) >>> w_srcb[4:0]);
      ALU_SLT:    w_alu = {31'd0, $signed(w_srca) < $signed(w_srcb)};
      ALU_SLTU:   w_alu = {31'd0, w_srca < w_srcb};
      ALU_MUL:    w_alu = w_prod[31:0];
      ALU_MULH,
      ALU_MULHSU,
      ALU_MULHU:  w_alu = w_prod[63:32];
      ALU_DIV,
      ALU_DIVU,
      ALU_REM,
      ALU_REMU:   w_alu = w_div_done ? w_div_res : 32'd0;
      default:    w_alu = 32'd0;
    endcase
  end

  // Branch condition on forwarded register operands.
  always_comb begin
    w_cond = 1'b0;
    case (br_type_e'(BranchTypeE))
      BR_BEQ:  w_cond = (w_srca == w_wd);
      BR_BNE:  w_cond = (w_srca != w_wd);
      BR_BLT:  w_cond = ($signed(w_srca) < $signed(w_wd));
      BR_BGE:  w_cond = ($signed(w_srca) >= $signed(w_wd));
      BR_BLTU: w_cond = (w_srca < w_wd);
      BR_BGEU: w_cond = (w_srca >= w_wd);
      default: w_cond = 1'b0;
    endcase
  end

  // JALR is a jump whose base comes from rs1 (immediate operand).
  assign w_jalr    = JumpE && ALUSrcE;
  assign PCTargetE = w_jalr ? ((w_srca + Imm_Ext_E) & ~32'd1)
                            : (PC_E + Imm_Ext_E);
  assign PCSrcE    = (JumpE || (BranchE && w_cond))
                     && !FlushE && !StallE;

  assign w_exm = '{
    regw: RegWriteE,
    memw: MemWriteE,
    rsrc: ResultSrcE,
    dex:  DexControlE,
    rd:   RD_E,
    pcp4: PCPlus4E,
    wd:   w_wd,
    alu:  w_alu,
    imm:  Imm_Ext_E,
    pct:  PCTargetE
  };

  // EX/MEM register: bubble on flush or stall.
  always_ff @(posedge CLK) begin
    if (Rst)
      r_exm <= '0;
    else if (FlushE || StallE)
      r_exm <= '0;
    else
      r_exm <= w_exm;
  end

  assign RegWriteM   = r_exm.regw;
  assign MemWriteM   = r_exm.memw;
  assign ResultSrcM  = r_exm.rsrc;
  assign DexControlM = r_exm.dex;
  assign RD_M        = r_exm.rd;
  assign PCPlus4M    = r_exm.pcp4;
  assign WriteDataM  = r_exm.wd;
  assign ALU_ResultM = r_exm.alu;
  assign Imm_Ext_M   = r_exm.imm;
  assign PCTargetM   = r_exm.pct;

endmodule

// File: tb/tb_execute_cycle.sv
// tb_execute_cycle: randomized self-checking bench for
// execute_cycle against an arithmetic reference model.
module tb_execute_cycle;
  import riscv_pkg::*;

  logic        CLK = 1'b0;
  logic        Rst;
  logic        RegWriteE, MemWriteE, BranchE, JumpE, ALUSrcE;
  logic [2:0]  ResultSrcE, DexControlE, BranchTypeE;
  logic [4:0]  ALUControlE;
  logic [31:0] RD1_E, RD2_E, Imm_Ext_E, PC_E, PCPlus4E;
  logic [4:0]  RD_E;
  logic [1:0]  ForwardAE, ForwardBE;
  logic [31:0] ResultW;
  logic        FlushE;
  logic        StallE, PCSrcE;
  logic [31:0] PCTargetE;
  logic        RegWriteM, MemWriteM;
  logic [2:0]  ResultSrcM, DexControlM;
  logic [4:0]  RD_M;
  logic [31:0] PCPlus4M, WriteDataM, ALU_ResultM;
  logic [31:0] Imm_Ext_M, PCTargetM;

  int n_cmp = 0;
  int n_err = 0;

  always #5 CLK = ~CLK;

  execute_cycle #(.XLEN(32)) dut (
    .CLK(CLK), .Rst(Rst),
    .RegWriteE(RegWriteE), .MemWriteE(MemWriteE),
    .BranchE(BranchE), .JumpE(JumpE), .ALUSrcE(ALUSrcE),
    .ResultSrcE(ResultSrcE), .DexControlE(DexControlE),
    .BranchTypeE(BranchTypeE), .ALUControlE(ALUControlE),
    .RD1_E(RD1_E), .RD2_E(RD2_E), .Imm_Ext_E(Imm_Ext_E),
    .PC_E(PC_E), .PCPlus4E(PCPlus4E), .RD_E(RD_E),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .ResultW(ResultW), .FlushE(FlushE),
    .StallE(StallE), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
    .RegWriteM(RegWriteM), .MemWriteM(MemWriteM),
    .ResultSrcM(ResultSrcM), .DexControlM(DexControlM),
    .RD_M(RD_M), .PCPlus4M(PCPlus4M), .WriteDataM(WriteDataM),
    .ALU_ResultM(ALU_ResultM), .Imm_Ext_M(Imm_Ext_M),
    .PCTargetM(PCTargetM)
  );

  function automatic logic [31:0] ref_div(
    input alu_op_e op, input logic [31:0] a, input logic [31:0] b);
    logic sgn, isr;
    sgn = (op == ALU_DIV) || (op == ALU_REM);
    isr = (op == ALU_REM) || (op == ALU_REMU);
    if (b == 32'd0)
      return isr ? a : 32'hFFFF_FFFF;
    if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
      return isr ? 32'd0 : 32'h8000_0000;
    if (sgn)
      return isr ? 32'($signed(a) % $signed(b))
                 : 32'($signed(a) / $signed(b));
    return isr ? a % b : a / b;
  endfunction

  function automatic logic [31:0] ref_alu(
    input alu_op_e op, input logic [31:0] a, input logic [31:0] b);
    longint          sp;
    longint unsigned up;
    case (op)
      ALU_ADD:  return a + b;
      ALU_SUB:  return a - b;
      ALU_AND:  return a & b;
      ALU_OR:   return a | b;
      ALU_XOR:  return a ^ b;
      ALU_SLL:  return a << b[4:0];
      ALU_SRL:  return a >> b[4:0];
      ALU_SRA:  return 32'($signed(a) >>> b[4:0]);
      ALU_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      ALU_SLTU: return (a < b) ? 32'd1 : 32'd0;
      ALU_MUL: begin
        up = 64'(a) * 64'(b);
        return up[31:0];
      end
      ALU_MULH: begin
        sp = longint'($signed(a)) * longint'($signed(b));
        return sp[63:32];
      end
      ALU_MULHSU: begin
        sp = longint'($signed(a)) * longint'({32'd0, b});
        return sp[63:32];
      end
      ALU_MULHU: begin
        up = 64'(a) * 64'(b);
        return up[63:32];
      end
      default: return ref_div(op, a, b);
    endcase
  endfunction

  function automatic logic ref_cond(
    input br_type_e t, input logic [31:0] a, input logic [31:0] b);
    case (t)
      BR_BEQ:  return a == b;
      BR_BNE:  return a != b;
      BR_BLT:  return $signed(a) < $signed(b);
      BR_BGE:  return $signed(a) >= $signed(b);
      BR_BLTU: return a < b;
      default: return a >= b;
    endcase
  endfunction

  task automatic drive(input alu_op_e op, input logic [31:0] a,
                       input logic [31:0] b, input logic rw);
    ALUControlE = op;
    RD1_E       = a;
    RD2_E       = b;
    RegWriteE   = rw;
    MemWriteE   = 1'b0;
    ALUSrcE     = 1'b0;
    ForwardAE   = FWD_RD;
    ForwardBE   = FWD_RD;
    BranchE     = 1'b0;
    JumpE       = 1'b0;
    FlushE      = 1'b0;
  endtask

  task automatic step();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic test_reset();
    Rst = 1'b1;
    drive(ALU_ADD, 32'd123, 32'd77, 1'b1);
    MemWriteE = 1'b1; ResultSrcE = 3'd1; DexControlE = 3'd2;
    BranchTypeE = 3'd0; Imm_Ext_E = 32'd9; PC_E = 32'd100;
    PCPlus4E = 32'd104; RD_E = 5'd3; ResultW = 32'd0;
    step();
    step();
    n_cmp++;
    if ({RegWriteM, MemWriteM, ResultSrcM, DexControlM, RD_M} !== '0) begin
      n_err++;
      $display("FAIL reset_ctrl got %h want 0",
               {RegWriteM, MemWriteM, ResultSrcM, DexControlM, RD_M});
    end
    n_cmp++;
    if ({PCPlus4M, WriteDataM, ALU_ResultM, Imm_Ext_M, PCTargetM} !== '0) begin
      n_err++;
      $display("FAIL reset_data got %h want 0", ALU_ResultM);
    end
    n_cmp++;
    if ({StallE, PCSrcE} !== 2'b00) begin
      n_err++;
      $display("FAIL reset_stall got %b want 00", {StallE, PCSrcE});
    end
    Rst = 1'b0;
  endtask

  task automatic test_add_forward();
    drive(ALU_ADD, 32'd2, 32'd3, 1'b1);
    step();
    n_cmp++;
    if (ALU_ResultM !== 32'd5) begin
      n_err++;
      $display("FAIL add_base got %h want 5", ALU_ResultM);
    end
    drive(ALU_ADD, 32'd999, 32'd7, 1'b1);
    ForwardAE = FWD_M;
    step();
    n_cmp++;
    if (ALU_ResultM !== 32'd12 || RegWriteM !== 1'b1) begin
      n_err++;
      $display("FAIL add_fwd got %h/%b want c/1", ALU_ResultM, RegWriteM);
    end
    drive(ALU_ADD, 32'd1, 32'd1, 1'b0);
    step();
    n_cmp++;
    if (RegWriteM !== 1'b0) begin
      n_err++;
      $display("FAIL add_rw0 got %b want 0", RegWriteM);
    end
  endtask

  task automatic test_alu_random();
    alu_op_e ops[14] = '{ALU_ADD, ALU_SUB, ALU_AND, ALU_OR,
      ALU_XOR, ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLT, ALU_SLTU,
      ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU};
    logic [31:0] prev, sa, wd, sb, exp;
    prev = 32'd0;
    for (int i = 0; i < 60; i++) begin
      alu_op_e op;
      op = ops[$urandom_range(0, 13)];
      drive(op, $urandom, $urandom, 1'($urandom_range(0, 1)));
      Imm_Ext_E = $urandom;
      ALUSrcE   = 1'($urandom_range(0, 1));
      ResultW   = $urandom;
      PC_E      = $urandom;
      RD_E      = 5'($urandom_range(0, 31));
      ForwardAE = (i == 0) ? FWD_RD : 2'($urandom_range(0, 2));
      ForwardBE = (i == 0) ? FWD_RD : 2'($urandom_range(0, 2));
      sa = (ForwardAE == FWD_W) ? ResultW :
           (ForwardAE == FWD_M) ? prev : RD1_E;
      wd = (ForwardBE == FWD_W) ? ResultW :
           (ForwardBE == FWD_M) ? prev : RD2_E;
      sb = ALUSrcE ? Imm_Ext_E : wd;
      exp = ref_alu(op, sa, sb);
      step();
      n_cmp++;
      if (ALU_ResultM !== exp) begin
        n_err++;
        $display("FAIL alu_%0d op=%0d got %h want %h",
                 i, op, ALU_ResultM, exp);
      end
      n_cmp++;
      if (WriteDataM !== wd || RegWriteM !== RegWriteE
          || RD_M !== RD_E || PCTargetM !== PC_E + Imm_Ext_E) begin
        n_err++;
        $display("FAIL alu_fields_%0d wd got %h want %h",
                 i, WriteDataM, wd);
      end
      prev = exp;
    end
  endtask

  task automatic test_branch();
    br_type_e bts[6] = '{BR_BEQ, BR_BNE, BR_BLT, BR_BGE,
                         BR_BLTU, BR_BGEU};
    logic exp;
    @(negedge CLK);
    drive(ALU_ADD, 32'hFFFF_FFFF, 32'd1, 1'b0);
    BranchE = 1'b1; BranchTypeE = BR_BLT;
    PC_E = 32'h100; Imm_Ext_E = 32'h40;
    #1;
    n_cmp++;
    if (PCSrcE !== 1'b1 || PCTargetE !== 32'h140) begin
      n_err++;
      $display("FAIL blt got %b/%h want 1/140", PCSrcE, PCTargetE);
    end
    BranchTypeE = BR_BLTU;
    #1;
    n_cmp++;
    if (PCSrcE !== 1'b0) begin
      n_err++;
      $display("FAIL bltu got %b want 0", PCSrcE);
    end
    for (int i = 0; i < 30; i++) begin
      br_type_e bt;
      logic [31:0] a, b;
      @(negedge CLK);
      bt = bts[$urandom_range(0, 5)];
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? a : $urandom;
      drive(ALU_ADD, a, b, 1'b0);
      BranchE = 1'b1; BranchTypeE = bt;
      ALUSrcE = 1'($urandom_range(0, 1));
      Imm_Ext_E = $urandom; PC_E = $urandom;
      FlushE = ($urandom_range(0, 4) == 0);
      exp = ref_cond(bt, a, b) && !FlushE;
      #1;
      n_cmp++;
      if (PCSrcE !== exp || PCTargetE !== PC_E + Imm_Ext_E) begin
        n_err++;
        $display("FAIL br_%0d t=%0d got %b/%h want %b/%h", i, bt,
                 PCSrcE, PCTargetE, exp, PC_E + Imm_Ext_E);
      end
    end
    @(negedge CLK);
    drive(ALU_ADD, 32'h1003, 32'd0, 1'b1);
    JumpE = 1'b1; PC_E = 32'h2000; Imm_Ext_E = 32'h10;
    #1;
    n_cmp++;
    if (PCSrcE !== 1'b1 || PCTargetE !== 32'h2010) begin
      n_err++;
      $display("FAIL jal got %b/%h want 1/2010", PCSrcE, PCTargetE);
    end
    ALUSrcE = 1'b1;
    #1;
    n_cmp++;
    if (PCSrcE !== 1'b1 || PCTargetE !== 32'h1012) begin
      n_err++;
      $display("FAIL jalr got %b/%h want 1/1012", PCSrcE, PCTargetE);
    end
    @(negedge CLK);
    drive(ALU_ADD, 32'd0, 32'd0, 1'b0);
    step();
  endtask

  task automatic test_div();
    alu_op_e dops[4] = '{ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
    alu_op_e op;
    logic [31:0] a, b, exp;
    int cnt;
    for (int i = 0; i < 7; i++) begin
      if (i == 0) begin
        op = ALU_DIV; a = -32'sd7; b = 32'd2;
      end else if (i == 1) begin
        op = ALU_REM; a = -32'sd7; b = 32'd2;
      end else begin
        op = dops[$urandom_range(0, 3)];
        a = $urandom;
        b = $urandom >> $urandom_range(0, 30);
        if (b == 32'd0 || b == 32'hFFFF_FFFF) b = 32'd3;
      end
      exp = ref_div(op, a, b);
      drive(op, a, b, 1'b1);
      #1;
      n_cmp++;
      if (StallE !== 1'b1) begin
        n_err++;
        $display("FAIL div_entry_%0d got %b want 1", i, StallE);
      end
      cnt = 0;
      while (StallE === 1'b1 && cnt < 40) begin
        cnt++;
        step();
        if (StallE === 1'b1 && RegWriteM !== 1'b0) begin
          n_cmp++;
          n_err++;
          $display("FAIL div_bubble_%0d got %b want 0", i, RegWriteM);
        end
      end
      n_cmp++;
      if (cnt != 33) begin
        n_err++;
        $display("FAIL div_stall_%0d got %0d want 33", i, cnt);
      end
      step();
      n_cmp++;
      if (ALU_ResultM !== exp || RegWriteM !== 1'b1) begin
        n_err++;
        $display("FAIL div_res_%0d op=%0d got %h want %h",
                 i, op, ALU_ResultM, exp);
      end
    end
    drive(ALU_ADD, 32'd0, 32'd0, 1'b0);
    step();
  endtask

  task automatic test_div_special();
    alu_op_e ops[4] = '{ALU_DIVU, ALU_DIV, ALU_REM, ALU_REMU};
    logic [31:0] as[4] = '{32'h1234_5678, 32'h8000_0000,
                           32'h8000_0000, 32'hDEAD_BEEF};
    logic [31:0] bs[4] = '{32'd0, 32'hFFFF_FFFF,
                           32'hFFFF_FFFF, 32'd0};
    logic [31:0] exps[4] = '{32'hFFFF_FFFF, 32'h8000_0000,
                             32'd0, 32'hDEAD_BEEF};
    for (int i = 0; i < 4; i++) begin
      drive(ops[i], as[i], bs[i], 1'b1);
      #1;
      n_cmp++;
      if (StallE !== 1'b0) begin
        n_err++;
        $display("FAIL spec_stall_%0d got %b want 0", i, StallE);
      end
      step();
      n_cmp++;
      if (ALU_ResultM !== exps[i]) begin
        n_err++;
        $display("FAIL spec_res_%0d got %h want %h",
                 i, ALU_ResultM, exps[i]);
      end
    end
  endtask

  task automatic test_flush_run();
    drive(ALU_DIV, 32'd1000, 32'd7, 1'b1);
    step();
    for (int k = 1; k < 10; k++) begin
      if (k == 5) begin
        JumpE = 1'b1;
        #1;
        n_cmp++;
        if (PCSrcE !== 1'b0 || StallE !== 1'b1) begin
          n_err++;
          $display("FAIL stall_jump got %b/%b want 0/1",
                   PCSrcE, StallE);
        end
        JumpE = 1'b0;
      end
      step();
    end
    FlushE = 1'b1;
    JumpE  = 1'b1;
    #1;
    n_cmp++;
    if (PCSrcE !== 1'b0 || StallE !== 1'b1) begin
      n_err++;
      $display("FAIL flush_cycle got %b/%b want 0/1", PCSrcE, StallE);
    end
    step();
    n_cmp++;
    if (RegWriteM !== 1'b0) begin
      n_err++;
      $display("FAIL flush_bubble got %b want 0", RegWriteM);
    end
    drive(ALU_ADD, 32'd1, 32'd2, 1'b1);
    #1;
    n_cmp++;
    if (StallE !== 1'b0) begin
      n_err++;
      $display("FAIL flush_idle got %b want 0", StallE);
    end
    step();
    n_cmp++;
    if (ALU_ResultM !== 32'd3 || RegWriteM !== 1'b1) begin
      n_err++;
      $display("FAIL flush_next got %h want 3", ALU_ResultM);
    end
  endtask

  task automatic test_rst_mid();
    drive(ALU_DIV, 32'd12345, 32'd3, 1'b1);
    for (int k = 0; k < 5; k++) step();
    Rst = 1'b1;
    drive(ALU_ADD, 32'd4, 32'd5, 1'b1);
    MemWriteE = 1'b1;
    step();
    n_cmp++;
    if ({RegWriteM, MemWriteM, ALU_ResultM, WriteDataM,
         PCPlus4M, PCTargetM, Imm_Ext_M, RD_M} !== '0) begin
      n_err++;
      $display("FAIL rst_mid_out got %h/%b want 0/0",
               ALU_ResultM, RegWriteM);
    end
    n_cmp++;
    if (StallE !== 1'b0) begin
      n_err++;
      $display("FAIL rst_mid_stall got %b want 0", StallE);
    end
    Rst = 1'b0;
    step();
    n_cmp++;
    if (ALU_ResultM !== 32'd9 || MemWriteM !== 1'b1) begin
      n_err++;
      $display("FAIL rst_after got %h want 9", ALU_ResultM);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_add_forward();
    test_alu_random();
    test_branch();
    test_div();
    test_div_special();
    test_flush_run();
    test_rst_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
